// File: rtl/sensor_requester.sv
// Sensor requester: sends an address and a command byte over a UART, then collects
// a one- or three-byte response and reports it with timeout / protocol-error status.
module sensor_requester #(
  parameter  int unsigned TIMEOUT_CYCLES = 50000000,
  localparam int unsigned BYTE_W         = 8
) (
  input  logic              i_Clock,
  input  logic              i_Reset_n,
  input  logic              i_Req_Start,
  input  logic [BYTE_W-1:0] i_Req_Address,
  input  logic [BYTE_W-1:0] i_Req_Command,
  output logic [BYTE_W-1:0] o_Tx_Data,
  output logic              o_Tx_Start,
  input  logic              i_Tx_Done,
  input  logic [BYTE_W-1:0] i_Rx_Data,
  input  logic              i_Rx_Done,
  output logic              o_Busy,
  output logic              o_Resp_Valid,
  output logic [BYTE_W-1:0] o_Resp_Code,
  output logic [BYTE_W-1:0] o_Resp_Integral,
  output logic [BYTE_W-1:0] o_Resp_Decimal,
  output logic              o_Timeout,
  output logic              o_Proto_Error
);

  localparam int unsigned CNT_W = 32;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // Response codes: two carry a value, three end the transaction after one byte
  localparam logic [BYTE_W-1:0] RC_DATA1      = BYTE_W'(8'h01);
  localparam logic [BYTE_W-1:0] RC_DATA2      = BYTE_W'(8'h02);
  localparam logic [BYTE_W-1:0] RC_ACK        = BYTE_W'(8'h00);
  localparam logic [BYTE_W-1:0] RC_SENSOR_ERR = BYTE_W'(8'h1F);
  localparam logic [BYTE_W-1:0] RC_BAD_CMD    = BYTE_W'(8'h2F);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    TX_ADDR   = 4'd1,
    WAIT_ADDR = 4'd2,
    TX_CMD    = 4'd3,
    WAIT_CMD  = 4'd4,
    RX_CODE   = 4'd5,
    RX_INT    = 4'd6,
    RX_DEC    = 4'd7,
    DONE      = 4'd8
  } state_t;

  state_t             state_q, state_d;
  logic               tx_done_q, rx_done_q;
  logic               tx_edge_c, rx_edge_c;
  logic               waiting_c, timeout_hit_c;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BYTE_W-1:0]  cmd_q, cmd_d;
  logic [BYTE_W-1:0]  tx_data_d, code_d, int_d, dec_d;
  logic               tx_start_d, busy_d, valid_d, tmo_d, perr_d;

  // Rising-edge detection against last cycle's sample of each done input
  assign tx_edge_c = i_Tx_Done & ~tx_done_q;
  assign rx_edge_c = i_Rx_Done & ~rx_done_q;

  assign waiting_c = state_q inside {WAIT_ADDR, WAIT_CMD, RX_CODE, RX_INT, RX_DEC};
  assign timeout_hit_c = waiting_c && (cnt_q == TMO_LAST);

  // Next-state and next-output logic; an edge always takes priority over a timeout
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    tx_data_d  = o_Tx_Data;
    tx_start_d = 1'b0;
    code_d     = o_Resp_Code;
    int_d      = o_Resp_Integral;
    dec_d      = o_Resp_Decimal;
    tmo_d      = o_Timeout;
    perr_d     = o_Proto_Error;

    case (state_q)
      IDLE: begin
        if (i_Req_Start && !o_Busy) begin
          state_d    = TX_ADDR;
          cmd_d      = i_Req_Command;
          tx_data_d  = i_Req_Address;
          tx_start_d = 1'b1;
          code_d     = '0;
          int_d      = '0;
          dec_d      = '0;
          tmo_d      = 1'b0;
          perr_d     = 1'b0;
        end
      end
      TX_ADDR: state_d = WAIT_ADDR;
      WAIT_ADDR: begin
        if (tx_edge_c) begin
          state_d    = TX_CMD;
          tx_data_d  = cmd_q;
          tx_start_d = 1'b1;
        end else if (timeout_hit_c) begin
          state_d = DONE;
          tmo_d   = 1'b1;
        end
      end
      TX_CMD: state_d = WAIT_CMD;
      WAIT_CMD: begin
        if (tx_edge_c) begin
          state_d = RX_CODE;
        end else if (timeout_hit_c) begin
          state_d = DONE;
          tmo_d   = 1'b1;
        end
      end
      RX_CODE: begin
        if (rx_edge_c) begin
          code_d = i_Rx_Data;
          case (i_Rx_Data)
            RC_DATA1, RC_DATA2:                 state_d = RX_INT;
            RC_ACK, RC_SENSOR_ERR, RC_BAD_CMD:  state_d = DONE;
            default: begin
              state_d = DONE;
              perr_d  = 1'b1;
            end
          endcase
        end else if (timeout_hit_c) begin
          state_d = DONE;
          tmo_d   = 1'b1;
        end
      end
      RX_INT: begin
        if (rx_edge_c) begin
          state_d = RX_DEC;
          int_d   = i_Rx_Data;
        end else if (timeout_hit_c) begin
          state_d = DONE;
          tmo_d   = 1'b1;
        end
      end
      RX_DEC: begin
        if (rx_edge_c) begin
          state_d = DONE;
          dec_d   = i_Rx_Data;
        end else if (timeout_hit_c) begin
          state_d = DONE;
          tmo_d   = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Counter restarts on every state change and only runs while waiting
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (waiting_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    // Valid lands the cycle after DONE; busy stretches to cover it
    valid_d = (state_q == DONE);
    busy_d  = (state_d != IDLE) || (state_q == DONE);
  end

  // State, counter, edge history and registered outputs
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      cmd_q           <= '0;
      tx_done_q       <= 1'b0;
      rx_done_q       <= 1'b0;
      o_Tx_Data       <= '0;
      o_Tx_Start      <= 1'b0;
      o_Busy          <= 1'b0;
      o_Resp_Valid    <= 1'b0;
      o_Resp_Code     <= '0;
      o_Resp_Integral <= '0;
      o_Resp_Decimal  <= '0;
      o_Timeout       <= 1'b0;
      o_Proto_Error   <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      cmd_q           <= cmd_d;
      tx_done_q       <= i_Tx_Done;
      rx_done_q       <= i_Rx_Done;
      o_Tx_Data       <= tx_data_d;
      o_Tx_Start      <= tx_start_d;
      o_Busy          <= busy_d;
      o_Resp_Valid    <= valid_d;
      o_Resp_Code     <= code_d;
      o_Resp_Integral <= int_d;
      o_Resp_Decimal  <= dec_d;
      o_Timeout       <= tmo_d;
      o_Proto_Error   <= perr_d;
    end
  end

endmodule

// File: tb/tb_sensor_requester.sv
// Directed bench for sensor_requester: normal transactions, single-byte responses,
// protocol error, timeouts, edge-vs-timeout priority, discards and mid-transaction reset.
module tb_sensor_requester;

  logic       i_Clock;
  logic       i_Reset_n;
  logic       i_Req_Start;
  logic [7:0] i_Req_Address;
  logic [7:0] i_Req_Command;
  logic [7:0] o_Tx_Data;
  logic       o_Tx_Start;
  logic       i_Tx_Done;
  logic [7:0] i_Rx_Data;
  logic       i_Rx_Done;
  logic       o_Busy;
  logic       o_Resp_Valid;
  logic [7:0] o_Resp_Code;
  logic [7:0] o_Resp_Integral;
  logic [7:0] o_Resp_Decimal;
  logic       o_Timeout;
  logic       o_Proto_Error;

  int total = 0;
  int bad   = 0;
  int n;

  sensor_requester #(.TIMEOUT_CYCLES(1000)) dut (
    .i_Clock         (i_Clock),
    .i_Reset_n       (i_Reset_n),
    .i_Req_Start     (i_Req_Start),
    .i_Req_Address   (i_Req_Address),
    .i_Req_Command   (i_Req_Command),
    .o_Tx_Data       (o_Tx_Data),
    .o_Tx_Start      (o_Tx_Start),
    .i_Tx_Done       (i_Tx_Done),
    .i_Rx_Data       (i_Rx_Data),
    .i_Rx_Done       (i_Rx_Done),
    .o_Busy          (o_Busy),
    .o_Resp_Valid    (o_Resp_Valid),
    .o_Resp_Code     (o_Resp_Code),
    .o_Resp_Integral (o_Resp_Integral),
    .o_Resp_Decimal  (o_Resp_Decimal),
    .o_Timeout       (o_Timeout),
    .o_Proto_Error   (o_Proto_Error)
  );

  initial i_Clock = 1'b0;
  always #5 i_Clock = ~i_Clock;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=no_finish required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge i_Clock);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_busy"},  o_Busy, 1'b0);
    chk1({tag, "_valid"}, o_Resp_Valid, 1'b0);
    chk1({tag, "_start"}, o_Tx_Start, 1'b0);
    chk8({tag, "_txd"},   o_Tx_Data, 8'h00);
    chk8({tag, "_code"},  o_Resp_Code, 8'h00);
    chk8({tag, "_int"},   o_Resp_Integral, 8'h00);
    chk8({tag, "_dec"},   o_Resp_Decimal, 8'h00);
    chk1({tag, "_tmo"},   o_Timeout, 1'b0);
    chk1({tag, "_perr"},  o_Proto_Error, 1'b0);
  endtask

  // Accept a request; returns in the first WAIT_ADDR cycle
  task automatic request(input logic [7:0] addr, input logic [7:0] cmd);
    i_Req_Address = addr;
    i_Req_Command = cmd;
    i_Req_Start   = 1'b1;
    step();
    i_Req_Start   = 1'b0;
    i_Req_Address = 8'hEE;
    i_Req_Command = 8'hEE;
    chk1("tx_start_addr", o_Tx_Start, 1'b1);
    chk8("tx_data_addr", o_Tx_Data, addr);
    chk1("busy_on", o_Busy, 1'b1);
    step();
    chk1("tx_start_one_cycle", o_Tx_Start, 1'b0);
    chk8("tx_data_addr_hold", o_Tx_Data, addr);
  endtask

  // Finish both UART sends; returns in the first RX_CODE cycle
  task automatic finish_tx(input logic [7:0] cmd);
    i_Tx_Done = 1'b1;
    step();
    i_Tx_Done = 1'b0;
    chk1("tx_start_cmd", o_Tx_Start, 1'b1);
    chk8("tx_data_cmd", o_Tx_Data, cmd);
    step();
    chk1("tx_start_cmd_one", o_Tx_Start, 1'b0);
    chk8("tx_data_cmd_hold", o_Tx_Data, cmd);
    i_Tx_Done = 1'b1;
    step();
    i_Tx_Done = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] data);
    i_Rx_Data = data;
    i_Rx_Done = 1'b1;
    step();
    i_Rx_Done = 1'b0;
    step();
  endtask

  // Final byte: valid must be low one cycle after the edge and high the next
  task automatic rx_last(input logic [7:0] data);
    i_Rx_Data = data;
    i_Rx_Done = 1'b1;
    step();
    i_Rx_Done = 1'b0;
    chk1("valid_not_early", o_Resp_Valid, 1'b0);
    step();
  endtask

  task automatic wait_valid(input int limit, output int cycles);
    cycles = 0;
    for (int i = 0; i < limit; i++) begin
      step();
      cycles++;
      if (o_Resp_Valid) break;
    end
    chk1("valid_seen", o_Resp_Valid, 1'b1);
  endtask

  task automatic end_txn();
    step();
    chk1("valid_one_cycle", o_Resp_Valid, 1'b0);
    chk1("busy_off", o_Busy, 1'b0);
  endtask

  initial begin
    i_Reset_n     = 1'b0;
    i_Req_Start   = 1'b0;
    i_Req_Address = 8'h00;
    i_Req_Command = 8'h00;
    i_Tx_Done     = 1'b0;
    i_Rx_Data     = 8'h00;
    i_Rx_Done     = 1'b0;
    repeat (3) step();
    chk_all_zero("reset");
    i_Reset_n = 1'b1;
    step();
    chk1("idle_busy", o_Busy, 1'b0);

    // Temperature read with a three-byte reply
    request(8'h00, 8'h04);
    finish_tx(8'h04);
    rx_byte(8'h02);
    rx_byte(8'h19);
    rx_last(8'h05);
    chk1("temp_valid", o_Resp_Valid, 1'b1);
    chk1("temp_busy_at_valid", o_Busy, 1'b1);
    chk8("temp_code", o_Resp_Code, 8'h02);
    chk8("temp_int", o_Resp_Integral, 8'h19);
    chk8("temp_dec", o_Resp_Decimal, 8'h05);
    chk1("temp_tmo", o_Timeout, 1'b0);
    chk1("temp_perr", o_Proto_Error, 1'b0);
    end_txn();
    chk8("temp_code_held", o_Resp_Code, 8'h02);

    // Status error: single byte, earlier data bytes cleared
    request(8'h10, 8'h03);
    finish_tx(8'h03);
    rx_last(8'h1F);
    chk1("stat_valid", o_Resp_Valid, 1'b1);
    chk8("stat_code", o_Resp_Code, 8'h1F);
    chk8("stat_int", o_Resp_Integral, 8'h00);
    chk8("stat_dec", o_Resp_Decimal, 8'h00);
    chk1("stat_perr", o_Proto_Error, 1'b0);
    end_txn();

    // Invalid command answered with 0x2F, then an unknown code
    request(8'h10, 8'h07);
    finish_tx(8'h07);
    rx_last(8'h2F);
    chk1("badcmd_valid", o_Resp_Valid, 1'b1);
    chk8("badcmd_code", o_Resp_Code, 8'h2F);
    chk1("badcmd_perr", o_Proto_Error, 1'b0);
    end_txn();
    request(8'h10, 8'h03);
    finish_tx(8'h03);
    rx_last(8'h55);
    chk1("perr_valid", o_Resp_Valid, 1'b1);
    chk8("perr_code", o_Resp_Code, 8'h55);
    chk1("perr_flag", o_Proto_Error, 1'b1);
    chk8("perr_int", o_Resp_Integral, 8'h00);
    end_txn();

    // Silence after the command: valid 1001 cycles after entering RX_CODE
    request(8'h10, 8'h04);
    finish_tx(8'h04);
    wait_valid(1100, n);
    chkn("tmo_code_latency", n, 1001);
    chk1("tmo_flag", o_Timeout, 1'b1);
    chk8("tmo_code", o_Resp_Code, 8'h00);
    chk1("tmo_perr", o_Proto_Error, 1'b0);
    end_txn();

    // Code 0x01 then silence: code kept, integral 0
    request(8'h10, 8'h05);
    finish_tx(8'h05);
    rx_byte(8'h01);
    wait_valid(1100, n);
    chkn("tmo_int_latency", n, 1000);
    chk1("tmo2_flag", o_Timeout, 1'b1);
    chk8("tmo2_code", o_Resp_Code, 8'h01);
    chk8("tmo2_int", o_Resp_Integral, 8'h00);
    chk8("tmo2_dec", o_Resp_Decimal, 8'h00);
    end_txn();

    // Edge in the very cycle the counter reaches its limit wins
    request(8'h10, 8'h03);
    finish_tx(8'h03);
    repeat (999) step();
    chk1("race_no_valid_yet", o_Resp_Valid, 1'b0);
    rx_last(8'h1F);
    chk1("race_valid", o_Resp_Valid, 1'b1);
    chk1("race_tmo", o_Timeout, 1'b0);
    chk8("race_code", o_Resp_Code, 8'h1F);
    end_txn();

    // Rx bytes in WAIT_ADDR discarded, start while busy ignored, reset in RX_INT
    request(8'h21, 8'h05);
    rx_byte(8'h99);
    chk8("discard_code", o_Resp_Code, 8'h00);
    chk1("discard_perr", o_Proto_Error, 1'b0);
    i_Req_Address = 8'h77;
    i_Req_Command = 8'h03;
    i_Req_Start   = 1'b1;
    step();
    i_Req_Start   = 1'b0;
    chk1("busy_start_ignored", o_Tx_Start, 1'b0);
    chk8("busy_txd_kept", o_Tx_Data, 8'h21);
    finish_tx(8'h05);
    rx_byte(8'h01);
    chk8("after_discard_code", o_Resp_Code, 8'h01);
    i_Reset_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    step();
    chk1("midreset_no_valid", o_Resp_Valid, 1'b0);
    i_Reset_n = 1'b1;
    step();
    chk1("post_reset_valid", o_Resp_Valid, 1'b0);
    chk1("post_reset_busy", o_Busy, 1'b0);
    request(8'h05, 8'h05);
    finish_tx(8'h05);
    rx_byte(8'h01);
    rx_byte(8'h20);
    rx_last(8'h07);
    chk1("recover_valid", o_Resp_Valid, 1'b1);
    chk8("recover_code", o_Resp_Code, 8'h01);
    chk8("recover_int", o_Resp_Integral, 8'h20);
    chk8("recover_dec", o_Resp_Decimal, 8'h07);
    chk1("recover_tmo", o_Timeout, 1'b0);
    chk1("recover_perr", o_Proto_Error, 1'b0);
    end_txn();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
